// File: rtl/gpp_pkg.sv
// rtl/gpp_pkg.sv - shared fetch states, IR field positions and halt opcode
package gpp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_EXEC,
    ST_HALTED
  } fetch_state_t;

  // IR field positions
  localparam int OPC_MSB      = 15;
  localparam int OPC_LSB      = 10;
  localparam int RA_BIT       = 9;
  localparam int RA_STACK_MSB = 9;
  localparam int RA_STACK_LSB = 8;
  localparam int BA_MSB       = 9;
  localparam int BA_LSB       = 0;
  localparam int IMM_MSB      = 8;
  localparam int IMM_LSB      = 0;

  localparam logic [5:0] GPP_HALT_OPC = 6'b111111;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with load and wrapping increment
module pc_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // Load wins over increment; increment wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_addr;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer driving the IR
module instr_fetch
  import gpp_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter int         DATA_W   = 16,
  parameter logic [5:0] HALT_OPC = GPP_HALT_OPC,
  parameter int         TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_in,
  output logic              ir_w,
  input  logic              exec_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_ir;
  logic              r_err;
  logic              r_halt_pend;
  logic [ADDR_W-1:0] w_pc;
  logic              w_in_req;
  logic              w_ack_ok;
  logic              w_timeout;
  logic              w_exec_fin;
  logic              w_is_halt;

  assign w_in_req   = (r_state == ST_REQ);
  assign w_ack_ok   = w_in_req && mem_ack;
  // The last allowed cycle still accepts an ack; only a missing ack times out
  assign w_timeout  = w_in_req && !mem_ack && (r_cnt == CNT_LAST);
  assign w_exec_fin = (r_state == ST_EXEC) && exec_done;
  assign w_is_halt  = (r_ir[OPC_MSB:OPC_LSB] == HALT_OPC);

  pc_unit #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (w_exec_fin && branch_en),
    .load_addr(branch_addr),
    .inc      (w_exec_fin && !branch_en),
    .pc       (w_pc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_ack_ok)       w_next = ST_LOAD;
        else if (w_timeout) w_next = ST_HALTED;
      end
      ST_LOAD: begin
        if (w_is_halt) w_next = ST_HALTED;
        else           w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) w_next = (r_halt_pend || halt_req) ? ST_IDLE : ST_REQ;
      end
      ST_HALTED: begin
        if (start) w_next = ST_REQ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Cycles spent in REQ without an ack; cleared whenever REQ is left or acked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_req && !mem_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Instruction word captured on the ack cycle, held until the next ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= '0;
    end else if (w_ack_ok) begin
      r_ir <= mem_rdata;
    end
  end

  // Sticky timeout flag, only cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // Remembers a halt request seen during the current fetch/execute pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt_pend <= 1'b0;
    end else if ((r_state == ST_IDLE) || (r_state == ST_HALTED) || w_exec_fin) begin
      r_halt_pend <= 1'b0;
    end else if (halt_req) begin
      r_halt_pend <= 1'b1;
    end
  end

  assign mem_req  = w_in_req;
  assign mem_addr = w_in_req ? w_pc : '0;
  assign ir_in    = r_ir;
  assign ir_w     = (r_state == ST_LOAD);
  assign pc       = w_pc;
  assign busy     = (r_state == ST_REQ) || (r_state == ST_LOAD) || (r_state == ST_EXEC);
  assign halted   = (r_state == ST_HALTED);
  assign err      = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir_in;
  logic        ir_w;
  logic        exec_done = 1'b0;
  logic        branch_en = 1'b0;
  logic [9:0]  branch_addr = '0;
  logic [9:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mem [1024];
  int          exp_pc = 0;
  int          exp_err = 0;
  int          ended;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir_in      (ir_in),
    .ir_w       (ir_w),
    .exec_done  (exec_done),
    .branch_en  (branch_en),
    .branch_addr(branch_addr),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nonhalt_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ((int'(w) >> 10) == 63) w = w ^ 16'h0400;
    return w;
  endfunction

  task automatic start_fetch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", mem_req, 1);
    chk("start_addr", mem_addr, exp_pc);
    chk("start_halted", halted, 0);
    chk("start_err", err, exp_err);
  endtask

  // hmode: 0 none, 1 halt_req in LOAD, 2 pulse early in EXEC, 3 with exec_done, 4 on ack cycle
  task automatic do_instr(input int ack_dly, input int exec_dly, input bit br,
                          input logic [9:0] baddr, input int hmode, output int fin);
    logic [15:0] word;
    bit          stop;
    word = mem[exp_pc];
    stop = (hmode != 0);
    for (int i = 0; i < ack_dly; i++) begin
      chk("req_wait", mem_req, 1);
      chk("addr_wait", mem_addr, exp_pc);
      chk("irw_wait", ir_w, 0);
      @(negedge clk);
    end
    chk("req_ack", mem_req, 1);
    chk("addr_ack", mem_addr, exp_pc);
    mem_ack   = 1'b1;
    mem_rdata = word;
    halt_req  = (hmode == 4);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    halt_req  = 1'b0;
    chk("irw_load", ir_w, 1);
    chk("ir_load", ir_in, word);
    chk("req_load", mem_req, 0);
    chk("busy_load", busy, 1);
    chk("pc_load", pc, exp_pc);
    chk("err_load", err, exp_err);
    if ((int'(word) >> 10) == 63) begin
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_irw", ir_w, 0);
      chk("halt_req_out", mem_req, 0);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, exp_pc);
      fin = 2;
      return;
    end
    halt_req = (hmode == 1);
    @(negedge clk);
    halt_req = 1'b0;
    for (int i = 0; i < exec_dly; i++) begin
      chk("irw_exec", ir_w, 0);
      chk("ir_exec", ir_in, word);
      chk("req_exec", mem_req, 0);
      chk("pc_exec", pc, exp_pc);
      halt_req    = (hmode == 2) && (i == 0);
      start       = 1'($urandom);
      branch_en   = 1'($urandom);
      branch_addr = 10'($urandom);
      @(negedge clk);
      halt_req = 1'b0;
    end
    start       = 1'b0;
    exec_done   = 1'b1;
    branch_en   = br;
    branch_addr = baddr;
    halt_req    = (hmode == 3) || (hmode == 2 && exec_dly == 0);
    @(negedge clk);
    exec_done = 1'b0;
    branch_en = 1'b0;
    halt_req  = 1'b0;
    exp_pc = br ? int'(baddr) : (exp_pc + 1) % 1024;
    chk("pc_next", pc, exp_pc);
    if (stop) begin
      chk("stop_busy", busy, 0);
      chk("stop_req", mem_req, 0);
      chk("stop_halted", halted, 0);
      fin = 1;
    end else begin
      chk("next_req", mem_req, 1);
      chk("next_addr", mem_addr, exp_pc);
      fin = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h6AB3;
    mem[1]     = nonhalt_word();
    mem[10'h3FF] = nonhalt_word();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir_in, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", mem_req, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_irw", ir_w, 0);
    chk("idle_halted", halted, 0);
    chk("idle_err", err, 0);

    // Immediate ack at pc 0, then delayed ack with branch to 0x3FF, then wrap
    start_fetch();
    do_instr(0, 0, 1'b0, 10'h000, 0, ended);
    do_instr(3, 1, 1'b1, 10'h3FF, 0, ended);
    mem[0] = 16'hFC00;
    do_instr(0, 0, 1'b0, 10'h000, 0, ended);
    chk("wrap_pc", pc, 0);

    // Halt opcode: IR written, no further requests, resume at the same pc
    do_instr(1, 0, 1'b0, 10'h000, 0, ended);
    chk("halt_ended", ended, 2);
    repeat (3) begin
      @(negedge clk);
      chk("halted_noreq", mem_req, 0);
    end
    mem[0] = nonhalt_word();
    start_fetch();
    do_instr(0, 2, 1'b0, 10'h000, 0, ended);

    // Timeout: 15 cycles without ack
    for (int i = 0; i < 15; i++) begin
      chk("to_req", mem_req, 1);
      @(negedge clk);
    end
    exp_err = 1;
    chk("to_err", err, 1);
    chk("to_req_off", mem_req, 0);
    chk("to_halted", halted, 1);
    chk("to_pc", pc, exp_pc);
    start_fetch();
    do_instr(14, 0, 1'b0, 10'h000, 0, ended);

    // Randomized instruction stream against the model
    for (int n = 0; n < 60; n++) begin
      do_instr($urandom_range(0, 14), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
               10'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0, ended);
      if (ended == 2) mem[exp_pc] = nonhalt_word();
      if (ended != 0) start_fetch();
    end

    // Asynchronous reset mid-request with an ack pending
    chk("pre_rst_req", mem_req, 1);
    #2;
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_irw", ir_w, 0);
    chk("arst_pc", pc, 0);
    chk("arst_ir", ir_in, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_irw", ir_w, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_ir", ir_in, 0);
    @(negedge clk);
    chk("late_ack_irw2", ir_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
